// File: rtl/candy_avb_test_qsys_descriptor_fetch.sv
// Descriptor ring walker: reads 3-word descriptors, presents owned ones downstream, optional status writeback.
// Stalls on m_waitrequest and desc_ready; writeback state exists only with DESC_FETCH_WB_EN defined.
module candy_avb_test_qsys_descriptor_fetch #(
   parameter int ADDR_W       = 10,
   parameter int READ_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_write,
   output logic [31:0]       m_writedata,
   output logic [3:0]        m_byteenable,
   input  logic              m_waitrequest,
   input  logic [31:0]       m_readdata,
   output logic              desc_valid,
   input  logic              desc_ready,
   output logic [31:0]       desc_src,
   output logic [31:0]       desc_dst,
   output logic [15:0]       desc_len,
   output logic              busy,
   output logic              stopped,
   output logic [CNT_W-1:0]  done_count
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_PRESENT, S_WB, S_NEXT} state_t;

   state_t                  r_state;
   logic [ADDR_W-1:0]       r_ptr;
   logic [ADDR_W-1:0]       r_base;
   logic [ADDR_W-1:0]       r_addr;
   logic                    r_read;
   logic                    r_valid;
   logic                    r_stopped;
   logic                    r_eol;
   logic [1:0]              r_rd_off;
   logic [31:0]             r_src;
   logic [31:0]             r_dst;
   logic [15:0]             r_len;
   logic [CNT_W-1:0]        r_done;
   logic [READ_LATENCY-1:0] r_pipe_vld;
   logic [1:0]              r_pipe_off [READ_LATENCY];

   logic                    w_rd_acc;
   logic                    w_rd_ret;
   logic [1:0]              w_ret_off;
   logic [ADDR_W-1:0]       w_ptr_next;
   logic [ADDR_W-1:0]       w_start_ptr;

   assign w_rd_acc    = r_read & ~m_waitrequest;
   assign w_rd_ret    = r_pipe_vld[READ_LATENCY-1];
   assign w_ret_off   = r_pipe_off[READ_LATENCY-1];
   assign w_ptr_next  = r_eol ? r_base : r_ptr + ADDR_W'(4);
   assign w_start_ptr = {base_addr[ADDR_W-1:2], 2'b00};

   assign m_address  = r_addr;
   assign m_read     = r_read;
   assign desc_valid = r_valid;
   assign desc_src   = r_src;
   assign desc_dst   = r_dst;
   assign desc_len   = r_len;
   assign busy       = (r_state != S_IDLE);
   assign stopped    = r_stopped;
   assign done_count = r_done;

`ifdef DESC_FETCH_WB_EN
   logic r_write;
   assign m_write     = r_write;
   assign m_writedata = r_write ? {1'b1, 15'b0, r_len} : 32'h0;
`else
   assign m_write     = 1'b0;
   assign m_writedata = 32'h0;
`endif
   assign m_byteenable = m_write ? 4'hF : 4'h0;

   // Each accepted read carries its word offset so returning data lands in the right field.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < READ_LATENCY; i++) r_pipe_off[i] <= 2'd0;
      end else begin
         r_pipe_vld[0] <= w_rd_acc;
         r_pipe_off[0] <= r_rd_off;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_off[i] <= r_pipe_off[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_base    <= '0;
         r_addr    <= '0;
         r_read    <= 1'b0;
         r_valid   <= 1'b0;
         r_stopped <= 1'b0;
         r_eol     <= 1'b0;
         r_rd_off  <= 2'd0;
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_done    <= '0;
`ifdef DESC_FETCH_WB_EN
         r_write   <= 1'b0;
`endif
      end else begin
         r_stopped <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ptr    <= w_start_ptr;
                  r_base   <= w_start_ptr;
                  r_addr   <= w_start_ptr;
                  r_read   <= 1'b1;
                  r_rd_off <= 2'd0;
                  r_state  <= S_RD;
               end
            end
            S_RD: begin
               if (w_rd_acc) begin
                  if (r_rd_off == 2'd2) begin
                     r_read <= 1'b0;
                  end else begin
                     r_rd_off <= r_rd_off + 2'd1;
                     r_addr   <= r_addr + ADDR_W'(1);
                  end
               end
               if (w_rd_ret) begin
                  case (w_ret_off)
                     2'd0: r_src <= m_readdata;
                     2'd1: r_dst <= m_readdata;
                     default: begin
                        r_eol <= m_readdata[30];
                        r_len <= m_readdata[15:0];
                        if (m_readdata[31]) begin
                           r_valid <= 1'b1;
                           r_state <= S_PRESENT;
                        end else begin
                           r_stopped <= 1'b1;
                           r_state   <= S_IDLE;
                        end
                     end
                  endcase
               end
            end
            S_PRESENT: begin
               if (desc_ready) begin
                  r_valid <= 1'b0;
`ifdef DESC_FETCH_WB_EN
                  r_write <= 1'b1;
                  r_addr  <= r_ptr + ADDR_W'(3);
                  r_state <= S_WB;
`else
                  r_done  <= r_done + CNT_W'(1);
                  r_state <= S_NEXT;
`endif
               end
            end
`ifdef DESC_FETCH_WB_EN
            S_WB: begin
               if (!m_waitrequest) begin
                  r_write <= 1'b0;
                  r_done  <= r_done + CNT_W'(1);
                  r_state <= S_NEXT;
               end
            end
`endif
            S_NEXT: begin
               r_ptr <= w_ptr_next;
               if (stop) begin
                  r_stopped <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_addr   <= w_ptr_next;
                  r_read   <= 1'b1;
                  r_rd_off <= 2'd0;
                  r_state  <= S_RD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
